// File: rtl/sci_host_link.sv
// Host-side SCI link master: sclk generation, byte serialiser, deserialiser, RX FIFO, flow control.
// Optional sticky error flags (err_frame, err_overrun, err_clear) are enabled by defining SCI_ERRSTAT_EN.
module sci_host_link #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       sci_sclk,
  output logic       sci_txd,
  input  logic       sci_txr_n,
  input  logic       sci_rxd,
  output logic       sci_rxr_n
`ifdef SCI_ERRSTAT_EN
  ,
  input  logic       err_clear,
  output logic       err_frame,
  output logic       err_overrun
`endif
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PW    = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned CW    = PW + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_HUNT, RX_DATA, RX_STOP} rx_state_e;

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             sclk_q, sclk_d;
  logic             fall_c, rise_c, div_wrap_c;
  logic [1:0]       txr_sync_q, txr_sync_d, rxd_sync_q, rxd_sync_d;
  logic             txr_n_s, rxd_s;

  tx_state_e        tx_state_q, tx_state_d;
  logic [7:0]       hold_q, hold_d, tx_shift_q, tx_shift_d;
  logic             hold_full_q, hold_full_d, tx_ready_q, tx_ready_d, txd_q, txd_d;
  logic [2:0]       tx_bit_q, tx_bit_d;

  rx_state_e        rx_state_q, rx_state_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic             push_req_c, push_ok_c, pop_c, full_c;

  logic [7:0]       mem_q [RX_FIFO_DEPTH];
  logic [7:0]       mem_d [RX_FIFO_DEPTH];
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_c, count_d;
  logic             rx_valid_q, rx_valid_d, rxr_n_q, rxr_n_d;
  logic [7:0]       rx_data_q, rx_data_d;

  // Free-running sclk divider; fall/rise mark the cycle whose edge toggles sclk
  assign div_wrap_c = (div_cnt_q == CNT_W'(CLK_DIV - 1));
  assign fall_c     = div_wrap_c && sclk_q;
  assign rise_c     = div_wrap_c && !sclk_q;

  always_comb begin
    div_cnt_d  = div_cnt_q + CNT_W'(1);
    sclk_d     = sclk_q;
    txr_sync_d = {txr_sync_q[0], sci_txr_n};
    rxd_sync_d = {rxd_sync_q[0], sci_rxd};
    if (div_wrap_c) begin
      div_cnt_d = '0;
      sclk_d    = ~sclk_q;
    end
  end

  assign txr_n_s = txr_sync_q[1];
  assign rxd_s   = rxd_sync_q[1];

  // Transmit: holding register feeds the shifter; the line only changes at a fall
  always_comb begin
    tx_state_d  = tx_state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_shift_d  = tx_shift_q;
    tx_bit_d    = tx_bit_q;
    txd_d       = txd_q;
    if (tx_valid && tx_ready_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
    if (fall_c) begin
      case (tx_state_q)
        TX_START: begin
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end
        TX_DATA: begin
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
        default: begin
          // IDLE and end of STOP both may launch the next frame
          txd_d      = 1'b1;
          tx_state_d = TX_IDLE;
          if (hold_full_q && !txr_n_s) begin
            txd_d       = 1'b0;
            tx_shift_d  = hold_q;
            hold_full_d = 1'b0;
            tx_state_d  = TX_START;
          end
        end
      endcase
    end
    tx_ready_d = ~hold_full_d;
  end

  // Receive: sample at every rise
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    push_req_c = 1'b0;
    if (rise_c) begin
      case (rx_state_q)
        RX_DATA: begin
          rx_shift_d = {rxd_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
        RX_STOP: begin
          push_req_c = rxd_s;
          rx_state_d = RX_HUNT;
        end
        default: begin
          if (!rxd_s) begin
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end
        end
      endcase
    end
  end

  // RX FIFO; a pop on a full FIFO frees the slot for a same-cycle push
  always_comb begin
    count_c   = wr_ptr_q - rd_ptr_q;
    full_c    = (count_c == CW'(RX_FIFO_DEPTH));
    pop_c     = rx_valid_q && rx_ready;
    push_ok_c = push_req_c && (!full_c || pop_c);
    wr_ptr_d  = wr_ptr_q + CW'(push_ok_c);
    rd_ptr_d  = rd_ptr_q + CW'(pop_c);
    count_d   = wr_ptr_d - rd_ptr_d;
    mem_d     = mem_q;
    if (push_ok_c) mem_d[wr_ptr_q[PW-1:0]] = rx_shift_q;
    rx_valid_d = (count_d != '0);
    rx_data_d  = rx_valid_d ? mem_d[rd_ptr_d[PW-1:0]] : 8'h00;
    rxr_n_d    = ((CW'(RX_FIFO_DEPTH) - count_d) < CW'(2));
  end

  always_ff @(posedge clk_clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      div_cnt_q   <= '0;
      sclk_q      <= 1'b1;
      txr_sync_q  <= 2'b11;
      rxd_sync_q  <= 2'b11;
      tx_state_q  <= TX_IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      tx_ready_q  <= 1'b0;
      tx_shift_q  <= 8'h00;
      tx_bit_q    <= 3'd0;
      txd_q       <= 1'b1;
      rx_state_q  <= RX_HUNT;
      rx_shift_q  <= 8'h00;
      rx_bit_q    <= 3'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rxr_n_q     <= 1'b1;
    end else begin
      div_cnt_q   <= div_cnt_d;
      sclk_q      <= sclk_d;
      txr_sync_q  <= txr_sync_d;
      rxd_sync_q  <= rxd_sync_d;
      tx_state_q  <= tx_state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_ready_q  <= tx_ready_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      txd_q       <= txd_d;
      rx_state_q  <= rx_state_d;
      rx_shift_q  <= rx_shift_d;
      rx_bit_q    <= rx_bit_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      rxr_n_q     <= rxr_n_d;
    end
  end

  assign sci_sclk  = sclk_q;
  assign sci_txd   = txd_q;
  assign tx_ready  = tx_ready_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign sci_rxr_n = rxr_n_q;

`ifdef SCI_ERRSTAT_EN
  logic err_frame_q, err_frame_d, err_overrun_q, err_overrun_d;
  logic frame_err_c, overrun_c;

  assign frame_err_c = rise_c && (rx_state_q == RX_STOP) && !rxd_s;
  assign overrun_c   = push_req_c && !push_ok_c;

  // Sticky flags; a set event beats a same-cycle clear
  always_comb begin
    err_frame_d   = err_frame_q;
    err_overrun_d = err_overrun_q;
    if (err_clear) begin
      err_frame_d   = 1'b0;
      err_overrun_d = 1'b0;
    end
    if (frame_err_c) err_frame_d   = 1'b1;
    if (overrun_c)   err_overrun_d = 1'b1;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;
`endif

endmodule
